// File: rtl/router_pkg.sv
// router_pkg
//   Definitions shared by the router port controllers.
//   - FLIT_W             : default flit width
//   - DIR_PE/S/N/E/W     : one-hot output-port request encodings
//   - VC_BIT, YHOP_*, XHOP_* : flit header field positions
//   - hop_step()         : moves a signed 4-bit hop count one step toward zero
package router_pkg;

  localparam int FLIT_W = 64;

  // Output-port request bits: bit0 PE, bit1 S, bit2 N, bit3 E, bit4 W
  localparam logic [4:0] DIR_PE = 5'b00001;
  localparam logic [4:0] DIR_S  = 5'b00010;
  localparam logic [4:0] DIR_N  = 5'b00100;
  localparam logic [4:0] DIR_E  = 5'b01000;
  localparam logic [4:0] DIR_W  = 5'b10000;

  // Header layout
  localparam int VC_BIT   = 63;
  localparam int YHOP_MSB = 55;
  localparam int YHOP_LSB = 52;
  localparam int XHOP_MSB = 51;
  localparam int XHOP_LSB = 48;

  // Two's-complement step toward zero. A negative hop is incremented and a
  // positive one decremented, so -8 (4'b1000) becomes -7 with no overflow.
  function automatic logic [3:0] hop_step(input logic [3:0] hop);
    return hop[3] ? (hop + 4'd1) : (hop - 4'd1);
  endfunction

endpackage

// File: rtl/ipctrl_route.sv
// ipctrl_route
//   Combinational XY (x first) route computation for one flit.
//   Ports:
//     flit_i  in  DATA_W  incoming flit
//     dir_o   out 5       one-hot output-port request
//     flit_o  out DATA_W  flit with the consumed hop stepped toward zero;
//                         all other bits, including the VC bit, unchanged
module ipctrl_route
  import router_pkg::*;
#(
  parameter int DATA_W = FLIT_W
) (
  input  logic [DATA_W-1:0] flit_i,
  output logic [4:0]        dir_o,
  output logic [DATA_W-1:0] flit_o
);

  logic [3:0] xHop;
  logic [3:0] yHop;

  assign xHop = flit_i[XHOP_MSB:XHOP_LSB];
  assign yHop = flit_i[YHOP_MSB:YHOP_LSB];

  // X is resolved fully before Y; a flit with both hops at zero has arrived
  // and is delivered to the local PE with its hops left as they are.
  always_comb begin
    dir_o  = DIR_PE;
    flit_o = flit_i;
    if (xHop != 4'd0) begin
      dir_o                     = xHop[3] ? DIR_W : DIR_E;
      flit_o[XHOP_MSB:XHOP_LSB] = hop_step(xHop);
    end else if (yHop != 4'd0) begin
      dir_o                     = yHop[3] ? DIR_S : DIR_N;
      flit_o[YHOP_MSB:YHOP_LSB] = hop_step(yHop);
    end
  end

endmodule

// File: rtl/ipctrl_vc.sv
// ipctrl_vc
//   Router input-port controller with two single-flit virtual-channel
//   buffers. The global polarity picks which VC is written from the link
//   (write side = ~polarity) and which is presented to the crossbar
//   (read side = polarity).
//   Ports:
//     clk       in  1       clock
//     reset     in  1       synchronous active-high reset
//     polarity  in  1       global VC phase, toggles every cycle
//     send_in   in  1       upstream flit valid
//     data_in   in  DATA_W  upstream flit
//     ready_in  out 1       write-side VC buffer is empty
//     clear     in  1       release of the read-side buffer
//     req       out 5       one-hot output-port request of the read-side VC
//     data_out  out DATA_W  hop-updated flit of the read-side VC
//     err       out 1       sticky protocol error
//   Build option:
//     IPCTRL_ERR_EN  when defined, err latches on overflow writes and
//                    spurious clears; otherwise err is tied low.
module ipctrl_vc
  import router_pkg::*;
#(
  parameter int DATA_W = FLIT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              send_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_in,
  input  logic              clear,
  output logic [4:0]        req,
  output logic [DATA_W-1:0] data_out,
  output logic              err
);

  logic [1:0]        full_q;
  logic [1:0]        full_d;
  logic [DATA_W-1:0] buf_q   [2];
  logic [DATA_W-1:0] buf_d   [2];
  logic [4:0]        route_q [2];
  logic [4:0]        route_d [2];

  logic              wrVc;
  logic              rdVc;
  logic              writeEn;
  logic              clearEn;
  logic [4:0]        routeDir;
  logic [DATA_W-1:0] routedFlit;

  assign wrVc = ~polarity;
  assign rdVc = polarity;

  // The write and read VCs always differ, so a write and a clear in the
  // same cycle never touch the same buffer.
  assign writeEn = send_in && !full_q[wrVc];
  assign clearEn = clear && full_q[rdVc];

  ipctrl_route #(
    .DATA_W (DATA_W)
  ) u_route (
    .flit_i (data_in),
    .dir_o  (routeDir),
    .flit_o (routedFlit)
  );

  // Next-state for the VC buffers. The stored flit carries the inverted VC
  // bit so it is already tagged for the next hop's VC.
  always_comb begin
    full_d  = full_q;
    buf_d   = buf_q;
    route_d = route_q;
    if (writeEn) begin
      full_d[wrVc]          = 1'b1;
      buf_d[wrVc]           = routedFlit;
      buf_d[wrVc][VC_BIT]   = ~routedFlit[VC_BIT];
      route_d[wrVc]         = routeDir;
    end
    if (clearEn) begin
      full_d[rdVc] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q     <= 2'b00;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      route_q[0] <= '0;
      route_q[1] <= '0;
    end else begin
      full_q     <= full_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      route_q[0] <= route_d[0];
      route_q[1] <= route_d[1];
    end
  end

  // Outputs depend only on registers and polarity. data_out is shown even
  // when the VC is empty; req alone qualifies it.
  assign ready_in = ~full_q[wrVc];
  assign req      = full_q[rdVc] ? route_q[rdVc] : 5'b00000;
  assign data_out = buf_q[rdVc];

`ifdef IPCTRL_ERR_EN
  logic errEvent;
  logic err_q;
  logic err_d;

  // Overflow: sending into a full write-side VC. Spurious clear: clearing
  // an empty read-side VC. Either one latches until reset.
  assign errEvent = (send_in && full_q[wrVc]) || (clear && !full_q[rdVc]);

  always_comb begin
    err_d = err_q;
    if (errEvent) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ipctrl_vc.sv
// tb_ipctrl_vc
//   Directed bench for ipctrl_vc: a table of single-flit route vectors plus
//   hand-written multi-cycle sequences for back-to-back, overflow,
//   simultaneous write/clear and mid-traffic reset.
module tb_ipctrl_vc;

  logic        clk;
  logic        reset;
  logic        polarity;
  logic        send_in;
  logic [63:0] data_in;
  logic        ready_in;
  logic        clear;
  logic [4:0]  req;
  logic [63:0] data_out;
  logic        err;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [63:0] flit;
    logic [4:0]  expReq;
    logic [63:0] expData;
  } vec_t;

  vec_t vecs [7];

`ifdef IPCTRL_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  ipctrl_vc #(.DATA_W(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .send_in  (send_in),
    .data_in  (data_in),
    .ready_in (ready_in),
    .clear    (clear),
    .req      (req),
    .data_out (data_out),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds a flit from a fixed payload with the given header fields.
  function automatic logic [63:0] mkFlit(input logic vc, input logic [3:0] y,
                                         input logic [3:0] x);
    logic [63:0] f;
    f        = 64'h0A00_5678_9ABC_AAAA;
    f[63]    = vc;
    f[55:52] = y;
    f[51:48] = x;
    return f;
  endfunction

  task automatic applyStimulus(input logic s, input logic [63:0] d, input logic c);
    send_in = s;
    data_in = d;
    clear   = c;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock edge; polarity flips just after the edge like the global phase.
  task automatic tick();
    @(posedge clk);
    #1 polarity = ~polarity;
    #1;
  endtask

  task automatic waitPhase(input logic p);
    if (polarity !== p) tick();
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    polarity    = 1'b0;
    reset       = 1'b1;
    applyStimulus(1'b0, 64'h0, 1'b0);

    // Hand-computed route vectors
    vecs[0] = '{mkFlit(1'b0, 4'h0, 4'h2), 5'b01000, mkFlit(1'b1, 4'h0, 4'h1)};
    vecs[1] = '{mkFlit(1'b0, 4'hF, 4'h0), 5'b00010, mkFlit(1'b1, 4'h0, 4'h0)};
    vecs[2] = '{mkFlit(1'b0, 4'h3, 4'h8), 5'b10000, mkFlit(1'b1, 4'h3, 4'h9)};
    vecs[3] = '{mkFlit(1'b0, 4'h0, 4'h0), 5'b00001, mkFlit(1'b1, 4'h0, 4'h0)};
    vecs[4] = '{mkFlit(1'b0, 4'h7, 4'h0), 5'b00100, mkFlit(1'b1, 4'h6, 4'h0)};
    vecs[5] = '{mkFlit(1'b1, 4'h2, 4'hF), 5'b10000, mkFlit(1'b0, 4'h2, 4'h0)};
    vecs[6] = '{mkFlit(1'b1, 4'h8, 4'h7), 5'b01000, mkFlit(1'b0, 4'h8, 4'h6)};

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset req", {59'h0, req}, 64'h0);
    checkOutput("reset data_out", data_out, 64'h0);
    checkOutput("reset ready_in", {63'h0, ready_in}, 64'h1);
    checkOutput("reset err", {63'h0, err}, 64'h0);

    // Table-driven: write into VC1, check request, clear, check release
    for (int i = 0; i < 7; i++) begin
      waitPhase(1'b0);
      applyStimulus(1'b1, vecs[i].flit, 1'b0);
      tick();
      applyStimulus(1'b0, 64'h0, 1'b0);
      checkOutput($sformatf("vec%0d req", i), {59'h0, req}, {59'h0, vecs[i].expReq});
      checkOutput($sformatf("vec%0d data_out", i), data_out, vecs[i].expData);
      checkOutput($sformatf("vec%0d ready_in", i), {63'h0, ready_in}, 64'h1);
      applyStimulus(1'b0, 64'h0, 1'b1);
      tick();
      applyStimulus(1'b0, 64'h0, 1'b0);
      checkOutput($sformatf("vec%0d ready after clear", i), {63'h0, ready_in}, 64'h1);
      tick();
      checkOutput($sformatf("vec%0d req after clear", i), {59'h0, req}, 64'h0);
    end

    // Back-to-back: A into VC1, B into VC0, C overflows and is dropped
    waitPhase(1'b0);
    applyStimulus(1'b1, mkFlit(1'b0, 4'h0, 4'h1), 1'b0);
    tick();
    checkOutput("b2b req A", {59'h0, req}, {59'h0, 5'b01000});
    applyStimulus(1'b1, mkFlit(1'b0, 4'h0, 4'h0), 1'b0);
    tick();
    checkOutput("b2b ready ph0", {63'h0, ready_in}, 64'h0);
    checkOutput("b2b req B", {59'h0, req}, {59'h0, 5'b00001});
    checkOutput("b2b data B", data_out, mkFlit(1'b1, 4'h0, 4'h0));
    applyStimulus(1'b1, mkFlit(1'b0, 4'h5, 4'h0), 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0);
    checkOutput("b2b ready ph1", {63'h0, ready_in}, 64'h0);
    checkOutput("b2b req A held", {59'h0, req}, {59'h0, 5'b01000});
    checkOutput("b2b data A kept", data_out, mkFlit(1'b1, 4'h0, 4'h0));
    checkOutput("overflow err", {63'h0, err}, {63'h0, ERR_ON});
    // Clear VC1 on its read phase; it accepts again on its next write phase
    applyStimulus(1'b0, 64'h0, 1'b1);
    tick();
    checkOutput("vc1 ready again", {63'h0, ready_in}, 64'h1);
    checkOutput("vc0 still req", {59'h0, req}, {59'h0, 5'b00001});
    applyStimulus(1'b1, mkFlit(1'b0, 4'hE, 4'h0), 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0);
    checkOutput("vc1 refill req", {59'h0, req}, {59'h0, 5'b00010});
    checkOutput("vc1 refill data", data_out, mkFlit(1'b1, 4'hF, 4'h0));

    // Simultaneous write VC1 / clear VC0: free VC1 first
    applyStimulus(1'b0, 64'h0, 1'b1);
    tick();
    applyStimulus(1'b1, mkFlit(1'b0, 4'h0, 4'hC), 1'b1);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0);
    checkOutput("simul write req", {59'h0, req}, {59'h0, 5'b10000});
    checkOutput("simul write data", data_out, mkFlit(1'b1, 4'h0, 4'hD));
    tick();
    checkOutput("simul clear req", {59'h0, req}, 64'h0);
    checkOutput("simul vc1 full", {63'h0, ready_in}, 64'h0);

    // Fill VC0 too, then reset with both VCs full
    tick();
    applyStimulus(1'b1, mkFlit(1'b0, 4'h1, 4'h0), 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0);
    checkOutput("both full vc0 req", {59'h0, req}, {59'h0, 5'b00100});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset req", {59'h0, req}, 64'h0);
    checkOutput("midreset data", data_out, 64'h0);
    checkOutput("midreset ready", {63'h0, ready_in}, 64'h1);
    checkOutput("midreset err", {63'h0, err}, 64'h0);
    tick();
    checkOutput("midreset req ph2", {59'h0, req}, 64'h0);

    // Spurious clear of an empty VC
    applyStimulus(1'b0, 64'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0);
    checkOutput("spurious req", {59'h0, req}, 64'h0);
    checkOutput("spurious ready", {63'h0, ready_in}, 64'h1);
    checkOutput("spurious err", {63'h0, err}, {63'h0, ERR_ON});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ipctrl_vc.md
# ipctrl_vc

Router input-port controller: the receive end of the inter-router link whose transmit end is the output-port controller (opctrl). It accepts 64-bit flits from an upstream router or the local PE into two single-flit virtual-channel buffers (even/odd), alternating with the global polarity. It computes the XY route and presents a one-hot output-port request plus the hop-updated flit to the crossbar. A buffer is released when the granting output controller pulses this port's clear line.

## Interface
- `DATA_W`, default 64: flit width.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `polarity`  in  1  global VC phase; toggles every cycle. 0: external writes go to VC1, internal side reads VC0. 1: the roles swap.
- `send_in`  in  1  upstream flit valid.
- `data_in`  in  DATA_W  upstream flit.
- `ready_in`  out  1  write-side VC buffer empty. The upstream sender may only assert `send_in` when this is 1.
- `clear`  in  1  release of the read-side buffer. It is the OR of the matching `clear_*` outputs from the five output controllers.
- `req`  out  5  one-hot output request: bit0 PE, bit1 S, bit2 N, bit3 E, bit4 W.
- `data_out`  out  DATA_W  hop-updated flit from the read-side buffer.
- `err`  out  1  sticky protocol error. Only active with `IPCTRL_ERR_EN`.

## Operation
- Flit header fields:
  - [63] VC bit.
  - [55:52] signed 4-bit y_hop: positive = N, negative = S.
  - [51:48] signed 4-bit x_hop: positive = E, negative = W.
  - All other bits are payload, passed unchanged.
- State per VC v ∈ {0,1}: `full[v]`, `buf[v]` (the updated flit), `route[v]` (5-bit one-hot).
- Write-side VC: wv = ~polarity. Read-side VC: rv = polarity.
- Write: on a clock edge with `send_in && !full[wv]`:
  - Route is computed combinationally from `data_in`.
  - `buf[wv]` ← flit with the hop field updated and bit63 inverted (the VC for the next hop).
  - `route[wv]` ← route; `full[wv]` ← 1.
- Route (XY, x first):
  - x_hop ≠ 0: E if positive, W if negative. x_hop moves one step toward 0.
  - Else y_hop ≠ 0: N if positive, S if negative. y_hop moves one step toward 0.
  - Else PE; hops are left unchanged.
  - Hop arithmetic is 4-bit two's complement. Value −8 is legal and steps to −7.
- Request outputs:
  - `req = full[rv] ? route[rv] : 5'b0`.
  - `data_out = buf[rv]`, held even when empty. Never X after reset.
- Clear: `clear && full[rv]` → `full[rv]` ← 0 at the edge.
- Boundary cases:
  - `clear` while `full[rv]==0`: ignored.
  - `send_in` while `full[wv]==1`: ignored; the buffer keeps its old flit.
  - A write to wv and a clear of rv in the same cycle both take effect, since they target different VCs.
  - `req` holds stable until cleared, regardless of grant arbitration delay. The buffer waits across polarity phases; it is requested again each time its VC is read-side.
- Reset: `full` = 2'b00, `buf` = 0, `route` = 0, `err` = 0. Hence `req` = 0, `data_out` = 0, `ready_in` = 1. Reset mid-packet drops both buffered flits.

## Timing
- `ready_in`, `req`, `data_out` are combinational from registers and `polarity` only. No combinational path from `send_in` or `clear` to any output.
- Latency:
  - Flit written at edge k (polarity p).
  - Polarity becomes ~p at edge k, so that VC is read-side in cycle k..k+1.
  - `req` is asserted one cycle after the write.
- Clear sampled at edge j: `req` drops in the cycle after j, and `ready_in` returns when that VC is next write-side.
- Throughput: one flit per VC per two cycles. Aggregate is one flit per cycle when downstream clears every phase.

## Configuration
- `IPCTRL_ERR_EN` defined: `err` is set, and stays set until reset, on either of:
  - `send_in && full[wv]` (overflow);
  - `clear && !full[rv]` (spurious clear).
- `IPCTRL_ERR_EN` undefined: `err` is tied 0 and the detection logic is absent.

## Structure
- Shared package `router_pkg`:
  - direction one-hot constants `DIR_PE/S/N/E/W`;
  - header field positions `VC_BIT`, `YHOP_MSB/LSB`, `XHOP_MSB/LSB`;
  - the flit width default.
- Sub-module `ipctrl_route`: combinational XY route. Input is the flit; outputs are the one-hot direction and the hop-updated flit. It is instantiated once on the write path.

## Test plan
- **Reset:** reset=1 for 2 cycles → `req`=0, `data_out`=0, `ready_in`=1, `err`=0.
- **East route:** polarity=0, `send_in` with x_hop=+2, y_hop=0, payload 0xAAAA → next cycle `req`=5'b01000, `data_out` x_hop=+1, bit63 inverted. Pulse `clear` → `req`=0 the following cycle.
- **West then south:** x_hop=0, y_hop=−1 → `req`=5'b00010 (S), y_hop=0. Separately, x_hop=−8 → `req`=W, x_hop=−7.
- **Local delivery:** x_hop=0, y_hop=0 → `req`=5'b00001, flit unchanged except bit63.
- **Back-to-back:** writes on consecutive cycles fill VC1 then VC0 → `ready_in`=0 on both phases. A third `send_in` is ignored; with `IPCTRL_ERR_EN`, `err`=1. Then `clear` on VC1's read phase → VC1 accepts again two cycles later.
- **Simultaneous and mid-reset:** write wv and clear rv in the same cycle → both take effect. Reset asserted while both VCs are full → both dropped, `req`=0 next cycle.
